// File: rtl/cv32e41p_pkg.sv
// cv32e41p_pkg: shared constants and types for the register-file writeback queue.
package cv32e41p_pkg;

    localparam int REG_ZERO_ADDR = 0;
    localparam int WB_ADDR_WIDTH = 5;
    localparam int WB_DATA_WIDTH = 32;

    typedef struct packed {
        logic                     live;
        logic [WB_ADDR_WIDTH-1:0] addr;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/cv32e41p_rf_wb_queue.sv
// cv32e41p_rf_wb_queue: buffers multicycle writebacks and drains them onto RF port B when the LSU leaves it free.
module cv32e41p_rf_wb_queue
    import cv32e41p_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [ADDR_WIDTH-1:0]        req_addr_i,
    input  logic [DATA_WIDTH-1:0]        req_data_i,
    input  logic                         alu_we_i,
    input  logic [ADDR_WIDTH-1:0]        alu_waddr_i,
    input  logic                         portb_busy_i,
    output logic                         we_b_o,
    output logic [ADDR_WIDTH-1:0]        waddr_b_o,
    output logic [DATA_WIDTH-1:0]        wdata_b_o,
    input  logic [ADDR_WIDTH-1:0]        raddr_a_i,
    input  logic [ADDR_WIDTH-1:0]        raddr_b_i,
    input  logic [ADDR_WIDTH-1:0]        raddr_c_i,
    output logic                         hazard_a_o,
    output logic                         hazard_b_o,
    output logic                         hazard_c_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0]      live_q, live_d, kill, hit_a, hit_b, hit_c;
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  occupied, head_live, pop, acc, enq, req_kill;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        assign kill[i]  = alu_we_i && alu_waddr_i == addr_q[i];
        assign hit_a[i] = live_q[i] && addr_q[i] == raddr_a_i;
        assign hit_b[i] = live_q[i] && addr_q[i] == raddr_b_i;
        assign hit_c[i] = live_q[i] && addr_q[i] == raddr_c_i;
    end

    assign req_ready_o = count_q < CW'(DEPTH);
    assign count_o     = count_q;
    assign empty_o     = count_q == '0;
    assign occupied    = !empty_o;
    assign acc         = req_valid_i && req_ready_o;
    assign enq         = acc && req_addr_i != ADDR_WIDTH'(REG_ZERO_ADDR);
    assign req_kill    = alu_we_i && alu_waddr_i == req_addr_i;
    // An entry whose register is overwritten by port A this cycle is stale and leaves without a write.
    assign head_live   = live_q[head_q] && !kill[head_q];
    assign we_b_o      = occupied && head_live && !portb_busy_i;
    assign pop         = occupied && (!head_live || !portb_busy_i);
    assign waddr_b_o   = occupied ? addr_q[head_q] : '0;
    assign wdata_b_o   = occupied ? data_q[head_q] : '0;

    assign hazard_a_o = raddr_a_i != '0 && (|hit_a || (acc && req_addr_i == raddr_a_i));
    assign hazard_b_o = raddr_b_i != '0 && (|hit_b || (acc && req_addr_i == raddr_b_i));
    assign hazard_c_o = raddr_c_i != '0 && (|hit_c || (acc && req_addr_i == raddr_c_i));

    always_comb begin
        live_d  = live_q & ~kill;
        addr_d  = addr_q;
        data_d  = data_q;
        head_d  = pop ? head_q + PW'(1) : head_q;
        tail_d  = enq ? tail_q + PW'(1) : tail_q;
        count_d = count_q + CW'(enq) - CW'(pop);
        if (pop) live_d[head_q] = 1'b0;
        if (enq) begin
            live_d[tail_q] = !req_kill;
            addr_d[tail_q] = req_addr_i;
            data_d[tail_q] = req_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                addr_q[k] <= '0;
                data_q[k] <= '0;
            end
        end else begin
            live_q  <= live_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: doc/cv32e41p_rf_wb_queue.md
# cv32e41p_rf_wb_queue

Write-side feeder for the integer/FP register file. Buffers in-order writeback requests from multicycle units (divider, FPU) and drains them onto register-file write port B whenever the LSU is not using that port. Tracks pending destinations so decode can stall reads that would return stale data. Squashes queued writes superseded by a newer port-A (ALU) write.

## Interface
- ADDR_WIDTH, 5: register address width; 6 when the FP register file is present.
- DATA_WIDTH, 32: write data width.
- DEPTH, 4: queue entries; power of two, at least 2.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid_i  in  1  writeback request valid.
- req_ready_o  out  1  queue can accept a request this cycle.
- req_addr_i  in  ADDR_WIDTH  destination register.
- req_data_i  in  DATA_WIDTH  result data.
- alu_we_i  in  1  port-A write enable, snooped this cycle.
- alu_waddr_i  in  ADDR_WIDTH  port-A write address, snooped.
- portb_busy_i  in  1  LSU owns port B this cycle.
- we_b_o  out  1  port-B write enable.
- waddr_b_o  out  ADDR_WIDTH  port-B write address.
- wdata_b_o  out  DATA_WIDTH  port-B write data.
- raddr_a_i, raddr_b_i, raddr_c_i  in  ADDR_WIDTH each  decode read addresses.
- hazard_a_o, hazard_b_o, hazard_c_o  out  1 each  read address has a pending write.
- count_o  out  $clog2(DEPTH+1)  occupied entries.
- empty_o  out  1  count_o == 0.

## Operation
- Circular FIFO with `DEPTH` slots. Each slot holds {live, addr, data}, with head and tail pointers.
- Enqueue:
  - Occurs when req_valid_i && req_ready_o.
  - req_ready_o = (count < DEPTH), registered state only. It never depends on drain or req_valid_i.
  - A request with req_addr_i == 0 is acknowledged but not stored.
- Kill: alu_match(x) = alu_we_i && alu_waddr_i == x.
  - Each stored live entry with alu_match(addr) has live cleared at the clock edge.
  - A request enqueued in the same cycle as alu_match(req_addr_i) is stored with live=0.
- Drain, evaluated on the head slot when occupied:
  - head_eff_live = live && !alu_match(addr).
  - we_b_o = head_eff_live && !portb_busy_i.
  - Pop the head when (!head_eff_live) or we_b_o. Dead entries pop in one cycle without using the port.
- waddr_b_o and wdata_b_o always show the head slot's addr and data. They hold 0 when the queue is empty.
- Hazard:
  - hazard_x_o = (raddr_x != 0) && (any stored live entry has addr == raddr_x, or an enqueue this cycle has req_addr_i == raddr_x).
  - The head written this cycle still counts, because the register file updates only at the edge.
- Simultaneous enqueue and pop when full: not possible, since ready is low when full. Enqueue and pop when not full: count unchanged.
- Pointer wrap: modulo DEPTH.

## Timing
- Reset values: all slots invalid, pointers 0, count_o=0, empty_o=1, req_ready_o=1, we_b_o=0, waddr_b_o=0, wdata_b_o=0, hazard_*=0.
- There is no fall-through path. A request accepted in cycle N gives we_b_o=1 earliest in cycle N+1, and the register file holds the data after the N+1 edge.
- Throughput is one write per cycle while portb_busy_i=0.
- Combinational paths:
  - alu_* and portb_busy_i → we_b_o.
  - req_* and raddr_* → hazard_*.
  - Nothing → req_ready_o.
- Reset asserted mid-operation discards all entries immediately (asynchronous). Requests are lost; the issuing unit is reset too.

## Structure
- cv32e41p_pkg gains REG_ZERO_ADDR, and a wb_entry_t struct {live, addr, data} with default widths.
- Single module. The per-slot address comparators are generate loops, and no sub-module is warranted.

## Test plan
- Reset, then push addr=5 data=0xDEAD_BEEF with portb_busy_i=0 → we_b_o=1, waddr_b_o=5, wdata_b_o=0xDEADBEEF in the next cycle; hazard_a_o=1 for raddr_a_i=5 over both cycles; then empty_o=1.
- Hold portb_busy_i=1 and push 4 requests → count_o=4, req_ready_o=0, a 5th request is not accepted; release busy → four writes on consecutive cycles, in order.
- Queue holds addr=7 with busy=1; pulse alu_we_i with alu_waddr_i=7 → entry pops with no port-B write and hazard for 7 clears.
- Push addr=0 → req_ready_o stays 1, count_o stays 0, no write, hazard stays 0 for raddr=0.
- Enqueue addr=3 in the same cycle as ALU write to 3 → entry dead; hazard_x_o=1 only in that cycle; no port-B write for 3.
- Assert rst with 3 entries queued → count_o=0 and we_b_o=0 immediately, without waiting for a clock edge.
